// File: rtl/btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, debouncer, press/auto-repeat FSM and request latches.
// Define BTN_CONDITIONER_ACCEL_EN to let hold magnitude (mag) shorten the repeat period.
module btn_conditioner #(
  parameter int DEB_CYC  = 200000,
  parameter int REP_DLY  = 16000000,
  parameter int REP_PER  = 4000000,
  parameter int MAG_STEP = 20000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  logic       mode,
  input  logic       clr,
  output logic       out,
  output logic       once,
  output logic [1:0] mag
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
`ifdef BTN_CONDITIONER_ACCEL_EN
  localparam int HW = 32;
  localparam logic [63:0] MAG1 = 64'(MAG_STEP);
  localparam logic [63:0] MAG2 = MAG1 + MAG1;
  localparam logic [63:0] MAG3 = MAG2 + MAG1;
`else
  localparam int HW = (REP_DLY > 0) ? $clog2(REP_DLY + 1) : 1;
`endif

  typedef enum logic [2:0] {IDLE, PRESS, WAIT_REP, REPEAT, RELEASE} state_t;

  state_t          state, state_nx;
  logic            s1, s2, db;
  logic [DW-1:0]   deb_cnt;
  logic [HW-1:0]   hold;
  logic [31:0]     rep_cnt, per_nx, per_ld;
  logic [1:0]      mag_nx;
  logic            rep_entry, rep_fire, mag_chg, set_once, set_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {s2, s1} <= 2'b00;
    else        {s2, s1} <= {s1, in};
  end

  // Counter only runs while the synchronized level disagrees with db.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db      <= 1'b0;
      deb_cnt <= '0;
    end else if (s2 == db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
      db      <= s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Counts from the db rise cycle, so hold==N falls N cycles after the press event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        hold <= '0;
    else if (!db || state == RELEASE)  hold <= '0;
    else if (hold != '1)               hold <= hold + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (db) state_nx = PRESS;
      PRESS:    state_nx = db ? WAIT_REP : RELEASE;
      WAIT_REP: if (!db) state_nx = RELEASE;
                else if (hold >= HW'(REP_DLY)) state_nx = REPEAT;
      REPEAT:   if (!db) state_nx = RELEASE;
      RELEASE:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    mag_nx = 2'd0;
    per_nx = 32'(REP_PER);
`ifdef BTN_CONDITIONER_ACCEL_EN
    if (state != RELEASE) begin
      if      (64'(hold) >= MAG3) mag_nx = 2'd3;
      else if (64'(hold) >= MAG2) mag_nx = 2'd2;
      else if (64'(hold) >= MAG1) mag_nx = 2'd1;
    end
    per_nx = 32'(REP_PER) >> mag_nx;
`endif
  end

  // A zero period degenerates to firing every cycle rather than never.
  assign per_ld    = per_nx - 32'(per_nx != 32'd0);
  assign mag_chg   = (mag_nx != mag);
  assign rep_entry = (state == WAIT_REP) && (state_nx == REPEAT);
  assign rep_fire  = (state == REPEAT) && db && (rep_cnt == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       rep_cnt <= '0;
    else if (rep_entry || rep_fire)                   rep_cnt <= per_ld;
    else if (state == REPEAT && mag_chg)              rep_cnt <= per_ld;
    else if (state == REPEAT && rep_cnt != 32'd0)     rep_cnt <= rep_cnt - 32'd1;
    else if (state != REPEAT)                         rep_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mag <= 2'd0;
    else        mag <= mag_nx;
  end

  // Sets are taken on the edge that enters PRESS/REPEAT; a set beats a same-cycle clr.
  assign set_once = (state == IDLE) && db;
  assign set_out  = set_once || rep_entry || rep_fire || (mode && db);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= 1'b0;
      once <= 1'b0;
    end else begin
      if (set_out)      out <= 1'b1;
      else if (clr)     out <= 1'b0;
      if (set_once)     once <= 1'b1;
      else if (clr)     once <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DEB_CYC=4, REP_DLY=20, REP_PER=8, MAG_STEP=32).
// Edge k means the k-th rising edge after reset release; in is driven during cycle 0.
module tb_btn_conditioner;
  logic       clk = 1'b0;
  logic       rst_n, in, mode, clr;
  logic       out, once;
  logic [1:0] mag;
  int         checks = 0;
  int         errors = 0;

  btn_conditioner #(.DEB_CYC(4), .REP_DLY(20), .REP_PER(8), .MAG_STEP(32)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .clr(clr),
    .out(out), .once(once), .mag(mag)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start(input logic m, input logic c);
    rst_n = 1'b0; in = 1'b0; mode = m; clr = c;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in = 1'b0; mode = 1'b0; clr = 1'b0;
    #3;
    checks++;
    if ({out, once, mag} !== 4'b0000) begin
      errors++; $display("FAIL reset out/once/mag=%b exp 0000", {out, once, mag});
    end
  endtask

  task automatic test_press;
    logic [3:0] exp;
    start(1'b0, 1'b0);
    in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp = {((k >= 7 && k < 15) || k >= 27), (k >= 7 && k < 15), 2'b00};
      checks++;
      if ({out, once, mag} !== exp) begin
        errors++; $display("FAIL press k=%0d out/once/mag=%b exp %b", k, {out, once, mag}, exp);
      end
      clr = (k == 14);
    end
  endtask

  task automatic test_glitch;
    logic [3:0] exp;
    start(1'b0, 1'b0);
    in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      in = (k < 3);
      checks++;
      if ({out, once, mag} !== 4'b0000) begin
        errors++; $display("FAIL glitch k=%0d out/once/mag=%b exp 0000", k, {out, once, mag});
      end
    end
    // A pulse of exactly DEB_CYC cycles must register as a press.
    start(1'b0, 1'b0);
    in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      in = (k < 4);
      exp = {(k >= 7), (k >= 7), 2'b00};
      checks++;
      if ({out, once, mag} !== exp) begin
        errors++; $display("FAIL min_pulse k=%0d out/once/mag=%b exp %b", k, {out, once, mag}, exp);
      end
    end
  endtask

`ifndef BTN_CONDITIONER_ACCEL_EN
  task automatic test_repeat;
    logic [3:0] exp;
    logic       eo;
    start(1'b0, 1'b1);
    in = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      tick();
      in = (k < 60);
      eo = (k == 7) || (k >= 27 && k <= 59 && (k - 27) % 8 == 0);
      exp = {eo, (k == 7), 2'b00};
      checks++;
      if ({out, once, mag} !== exp) begin
        errors++; $display("FAIL repeat k=%0d out/once/mag=%b exp %b", k, {out, once, mag}, exp);
      end
    end
  endtask
`else
  task automatic test_accel;
    logic [3:0] exp;
    logic       eo;
    logic [1:0] em;
    start(1'b0, 1'b1);
    in = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      tick();
      in = (k < 130);
      eo = (k == 7) || (k == 27) || (k == 35) ||
           (k >= 43 && k <= 67 && (k - 43) % 4 == 0) ||
           (k >= 71 && k <= 101 && k % 2 == 1) || (k >= 103 && k <= 136);
      em = (k >= 138) ? 2'd0 : (k >= 103) ? 2'd3 : (k >= 71) ? 2'd2 : (k >= 39) ? 2'd1 : 2'd0;
      exp = {eo, (k == 7), em};
      checks++;
      if ({out, once, mag} !== exp) begin
        errors++; $display("FAIL accel k=%0d out/once/mag=%b exp %b", k, {out, once, mag}, exp);
      end
    end
  endtask
`endif

  task automatic test_continuous;
    logic [3:0] exp;
    start(1'b1, 1'b1);
    in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      in = (k < 10);
      exp = {(k >= 7 && k <= 16), (k == 7), 2'b00};
      checks++;
      if ({out, once, mag} !== exp) begin
        errors++; $display("FAIL continuous k=%0d out/once/mag=%b exp %b", k, {out, once, mag}, exp);
      end
    end
  endtask

  task automatic test_mode_switch;
    logic [3:0] exp;
    start(1'b0, 1'b1);
    in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      mode = (k >= 12 && k < 15);
      exp = {((k == 7) || (k >= 13 && k <= 15) || k == 27), (k == 7), 2'b00};
      checks++;
      if ({out, once, mag} !== exp) begin
        errors++; $display("FAIL mode_switch k=%0d out/once/mag=%b exp %b", k, {out, once, mag}, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp;
    start(1'b0, 1'b0);
    in = 1'b1;
    for (int k = 1; k <= 30; k++) tick();
    checks++;
    if ({out, once} !== 2'b11) begin
      errors++; $display("FAIL hold_before_reset out/once=%b exp 11", {out, once});
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({out, once, mag} !== 4'b0000) begin
      errors++; $display("FAIL async_reset out/once/mag=%b exp 0000", {out, once, mag});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {(k >= 7), (k >= 7), 2'b00};
      checks++;
      if ({out, once, mag} !== exp) begin
        errors++; $display("FAIL reset_repress k=%0d out/once/mag=%b exp %b", k, {out, once, mag}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
`ifndef BTN_CONDITIONER_ACCEL_EN
    test_repeat();
`else
    test_accel();
`endif
    test_continuous();
    test_mode_switch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
